// File: rtl/mdu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mdu_ctrl_pkg
// Shared CPU definitions for the multiply/divide unit: the MDUop command
// encodings, the controller FSM states, the default busy lengths and the
// width of the busy counter.
// ---------------------------------------------------------------------------
package mdu_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_NOP6  = 3'd6,
      OP_NOP7  = 3'd7
   } mdu_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } mdu_state_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // Wide enough for any sensible busy length; both cycle counts must be >= 1.
   localparam int CNT_W = 16;

endpackage

// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl
// Multi-cycle multiply/divide controller with the HI/LO register pair.
//
// Ports
//   clk    : single clock, all state changes on the rising edge
//   reset  : synchronous active-high reset
//   A      : operand rs (dividend / multiplicand / mthi-mtlo source)
//   B      : operand rt (divisor / multiplier)
//   MDUop  : 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
//   start  : one-cycle strobe qualifying MDUop, only honoured in IDLE
//   busy   : registered, high for exactly the loaded cycle count
//   HI, LO : registered result pair
// ---------------------------------------------------------------------------
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  MDUop,
   input  logic        start,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   mdu_state_e        state;
   logic [CNT_W-1:0]  counter;
   logic [31:0]       aReg;
   logic [31:0]       bReg;
   mdu_op_e           opReg;

   logic signed [63:0] prodSigned;
   logic [63:0]        prodUnsigned;
   logic               signedDiv;
   logic [31:0]        dividendMag;
   logic [31:0]        divisorMag;
   logic [31:0]        quotMag;
   logic [31:0]        remMag;
   logic [31:0]        quotient;
   logic [31:0]        remainder;
   logic [31:0]        resHi;
   logic [31:0]        resLo;
   logic               resWrite;

   // Result datapath, driven only by the latched operands so that anything
   // happening on A/B/MDUop during RUN cannot disturb the answer. Division is
   // done on magnitudes and the signs are reapplied afterwards: the quotient
   // is negative when the operand signs differ (truncation toward zero) and
   // the remainder follows the dividend. This also makes 0x80000000 / -1 come
   // out as quotient 0x80000000, remainder 0 without a special case, because
   // the magnitude 0x80000000 negates back onto itself. A zero divisor leaves
   // resWrite low so HI/LO keep their old values.
   always_comb begin
      prodSigned   = $signed({{32{aReg[31]}}, aReg}) * $signed({{32{bReg[31]}}, bReg});
      prodUnsigned = {32'd0, aReg} * {32'd0, bReg};
      signedDiv    = (opReg == OP_DIV);
      dividendMag  = (signedDiv && aReg[31]) ? (32'd0 - aReg) : aReg;
      divisorMag   = (signedDiv && bReg[31]) ? (32'd0 - bReg) : bReg;
      quotMag      = 32'd0;
      remMag       = 32'd0;
      if (divisorMag != 32'd0) begin
         quotMag = dividendMag / divisorMag;
         remMag  = dividendMag % divisorMag;
      end
      quotient  = (signedDiv && (aReg[31] ^ bReg[31])) ? (32'd0 - quotMag) : quotMag;
      remainder = (signedDiv && aReg[31]) ? (32'd0 - remMag) : remMag;

      resHi    = HI;
      resLo    = LO;
      resWrite = 1'b0;
      case (opReg)
         OP_MULT: begin
            resHi    = prodSigned[63:32];
            resLo    = prodSigned[31:0];
            resWrite = 1'b1;
         end
         OP_MULTU: begin
            resHi    = prodUnsigned[63:32];
            resLo    = prodUnsigned[31:0];
            resWrite = 1'b1;
         end
         OP_DIV, OP_DIVU: begin
            resHi    = remainder;
            resLo    = quotient;
            resWrite = (bReg != 32'd0);
         end
         default: begin
            resWrite = 1'b0;
         end
      endcase
   end

   // Controller FSM with registered busy and HI/LO. In IDLE a start either
   // launches a timed multiply/divide (operands latched, counter loaded,
   // busy raised) or, for mthi/mtlo, writes A straight into HI/LO without
   // ever entering RUN. In RUN every start is ignored, including the one in
   // the completing cycle; the counter ticks down and the edge that sees it
   // at 1 drops busy and writes the result together. Reset wins over all of
   // this, so a reset during RUN aborts without touching HI/LO beyond
   // clearing them.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         counter <= '0;
         busy    <= 1'b0;
         HI      <= 32'd0;
         LO      <= 32'd0;
         aReg    <= 32'd0;
         bReg    <= 32'd0;
         opReg   <= OP_MULT;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  case (MDUop)
                     OP_MULT, OP_MULTU: begin
                        aReg    <= A;
                        bReg    <= B;
                        opReg   <= mdu_op_e'(MDUop);
                        counter <= CNT_W'(MULT_CYCLES);
                        busy    <= 1'b1;
                        state   <= RUN;
                     end
                     OP_DIV, OP_DIVU: begin
                        aReg    <= A;
                        bReg    <= B;
                        opReg   <= mdu_op_e'(MDUop);
                        counter <= CNT_W'(DIV_CYCLES);
                        busy    <= 1'b1;
                        state   <= RUN;
                     end
                     OP_MTHI: begin
                        HI <= A;
                     end
                     OP_MTLO: begin
                        LO <= A;
                     end
                     default: begin
                        state <= IDLE;
                     end
                  endcase
               end
            end
            RUN: begin
               if (counter <= CNT_W'(1)) begin
                  counter <= '0;
                  busy    <= 1'b0;
                  state   <= IDLE;
                  if (resWrite) begin
                     HI <= resHi;
                     LO <= resLo;
                  end
               end else begin
                  counter <= counter - CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_ctrl
// Directed self-checking bench for mdu_ctrl with default cycle counts
// (mult 5, div 10). Inputs change and outputs are sampled on the falling
// edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_mdu_ctrl;

   logic        clk;
   logic        reset;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  MDUop;
   logic        start;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks = 0;
   int errors = 0;

   mdu_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .A     (A),
      .B     (B),
      .MDUop (MDUop),
      .start (start),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO)
   );

   // Free-running 100 MHz-style clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one command strobe. Returns on the falling edge right after the
   // accepting rising edge, i.e. inside busy cycle 1. Operand inputs are
   // scrambled afterwards so results can only come from latched values.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      MDUop = op;
      A     = a;
      B     = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A     = 32'hDEADBEEF;
      B     = 32'h0BADF00D;
      MDUop = 3'd7;
   endtask

   // Count falling edges on which busy is high, bounded so a stuck busy
   // shows up as a wrong count rather than a hang.
   task automatic countBusy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      A     = 32'h0;
      B     = 32'h0;
      MDUop = 3'd7;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, want 0", busy); end
      checks++;
      if (HI !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h, want 00000000", HI); end
      checks++;
      if (LO !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h, want 00000000", LO); end
   endtask

   task automatic test_mult();
      int n;
      applyStimulus(3'd0, 32'hFFFFFFFE, 32'd3);
      checks++;
      if (HI !== 32'h0) begin errors++; $display("[TB] FAIL mult_hi_early: got %h, want 00000000", HI); end
      countBusy(n);
      checks++;
      if (n != 5) begin errors++; $display("[TB] FAIL mult_busy_len: got %0d, want 5", n); end
      checks++;
      if (HI !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h, want ffffffff", HI); end
      checks++;
      if (LO !== 32'hFFFFFFFA) begin errors++; $display("[TB] FAIL mult_lo: got %h, want fffffffa", LO); end
   endtask

   task automatic test_divu_div();
      int n;
      applyStimulus(3'd3, 32'd17, 32'd5);
      countBusy(n);
      checks++;
      if (n != 10) begin errors++; $display("[TB] FAIL divu_busy_len: got %0d, want 10", n); end
      checks++;
      if (LO !== 32'd3) begin errors++; $display("[TB] FAIL divu_lo: got %h, want 00000003", LO); end
      checks++;
      if (HI !== 32'd2) begin errors++; $display("[TB] FAIL divu_hi: got %h, want 00000002", HI); end

      applyStimulus(3'd2, 32'hFFFFFFEF, 32'd5);
      countBusy(n);
      checks++;
      if (n != 10) begin errors++; $display("[TB] FAIL div_busy_len: got %0d, want 10", n); end
      checks++;
      if (LO !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_lo: got %h, want fffffffd", LO); end
      checks++;
      if (HI !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL div_hi: got %h, want fffffffe", HI); end
   endtask

   task automatic test_div_overflow();
      int n;
      applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF);
      countBusy(n);
      checks++;
      if (LO !== 32'h80000000) begin errors++; $display("[TB] FAIL ovf_lo: got %h, want 80000000", LO); end
      checks++;
      if (HI !== 32'h0) begin errors++; $display("[TB] FAIL ovf_hi: got %h, want 00000000", HI); end
   endtask

   task automatic test_div_zero();
      int n;
      applyStimulus(3'd4, 32'h11, 32'h0);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mthi_busy: got %b, want 0", busy); end
      applyStimulus(3'd5, 32'h22, 32'h0);
      checks++;
      if (HI !== 32'h11) begin errors++; $display("[TB] FAIL mthi_hi: got %h, want 00000011", HI); end
      checks++;
      if (LO !== 32'h22) begin errors++; $display("[TB] FAIL mtlo_lo: got %h, want 00000022", LO); end
      applyStimulus(3'd2, 32'h99, 32'h0);
      countBusy(n);
      checks++;
      if (n != 10) begin errors++; $display("[TB] FAIL divz_busy_len: got %0d, want 10", n); end
      checks++;
      if (HI !== 32'h11) begin errors++; $display("[TB] FAIL divz_hi: got %h, want 00000011", HI); end
      checks++;
      if (LO !== 32'h22) begin errors++; $display("[TB] FAIL divz_lo: got %h, want 00000022", LO); end
   endtask

   task automatic test_mtlo();
      int n;
      applyStimulus(3'd5, 32'h1234, 32'h0);
      checks++;
      if (LO !== 32'h1234) begin errors++; $display("[TB] FAIL mtlo_idle_lo: got %h, want 00001234", LO); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mtlo_idle_busy: got %b, want 0", busy); end

      applyStimulus(3'd3, 32'h50, 32'h0);
      @(negedge clk);
      MDUop = 3'd5;
      A     = 32'h5555;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      MDUop = 3'd7;
      countBusy(n);
      checks++;
      if (n + 2 != 10) begin errors++; $display("[TB] FAIL mtlo_run_busy_len: got %0d, want 10", n + 2); end
      checks++;
      if (LO !== 32'h1234) begin errors++; $display("[TB] FAIL mtlo_run_lo: got %h, want 00001234", LO); end
   endtask

   task automatic test_nop();
      applyStimulus(3'd6, 32'hAAAA, 32'hBBBB);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nop_busy: got %b, want 0", busy); end
      checks++;
      if (HI !== 32'h11 || LO !== 32'h1234) begin
         errors++;
         $display("[TB] FAIL nop_hilo: got %h/%h, want 00000011/00001234", HI, LO);
      end
   endtask

   task automatic test_ignored_start();
      int n;
      applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (2) @(negedge clk);
      MDUop = 3'd2;
      A     = 32'd100;
      B     = 32'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      MDUop = 3'd7;
      countBusy(n);
      checks++;
      if (n + 3 != 5) begin errors++; $display("[TB] FAIL ign_busy_len: got %0d, want 5", n + 3); end
      checks++;
      if (HI !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL ign_hi: got %h, want fffffffe", HI); end
      checks++;
      if (LO !== 32'h00000001) begin errors++; $display("[TB] FAIL ign_lo: got %h, want 00000001", LO); end
      repeat (12) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || LO !== 32'h00000001) begin
         errors++;
         $display("[TB] FAIL ign_no_late_run: got busy=%b lo=%h, want busy=0 lo=00000001", busy, LO);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      applyStimulus(3'd0, 32'd2, 32'd3);
      repeat (4) @(negedge clk);
      MDUop = 3'd1;
      A     = 32'd7;
      B     = 32'd7;
      start = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL last_cycle_start_busy: got %b, want 0", busy); end
      checks++;
      if (LO !== 32'd6 || HI !== 32'd0) begin
         errors++;
         $display("[TB] FAIL last_cycle_start_result: got %h/%h, want 00000000/00000006", HI, LO);
      end
      @(negedge clk);
      start = 1'b0;
      MDUop = 3'd7;
      countBusy(n);
      checks++;
      if (n != 5) begin errors++; $display("[TB] FAIL b2b_busy_len: got %0d, want 5", n); end
      checks++;
      if (LO !== 32'd49) begin errors++; $display("[TB] FAIL b2b_lo: got %h, want 00000031", LO); end
   endtask

   task automatic test_reset_mid();
      applyStimulus(3'd2, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_busy_before: got %b, want 1", busy); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b, want 0", busy); end
      checks++;
      if (HI !== 32'h0 || LO !== 32'h0) begin
         errors++;
         $display("[TB] FAIL rstmid_hilo: got %h/%h, want 00000000/00000000", HI, LO);
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rstmid_late_write: cycle %0d got busy=%b %h/%h, want 0 00000000/00000000", i, busy, HI, LO);
         end
      end
   endtask

   // Scenario sequence; each task leaves the DUT idle for the next one.
   initial begin
      test_reset();
      test_mult();
      test_divu_div();
      test_div_overflow();
      test_div_zero();
      test_mtlo();
      test_nop();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
